// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_ctrl_pkg                                               |
// | Description : State encoding and default constants for cpu_run_ctrl.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RST       = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_WAIT = 3'd2,
    S_STEP      = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  localparam int C_SYNC_STAGES     = 2;
  localparam int C_DEBOUNCE_CYCLES = 16;
  localparam int C_HOLD_CYCLES     = 4;
  localparam int C_CNT_W           = 32;

endpackage
`default_nettype wire

// File: rtl/debounce_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : debounce_sync                                              |
// | Description : Synchroniser, debounce counter and rising-edge pulse.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module debounce_sync
  import cpu_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = C_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_rise
);

  localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [c_cnt_w-1:0]     r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   w_synced;
  logic                   w_differ;
  logic                   w_accept;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_differ = (w_synced != r_level);
  // r_cnt holds how many disagreeing samples precede the current one
  assign w_accept = w_differ && (r_cnt == c_cnt_w'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if (!w_differ || w_accept)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (w_accept)
        r_level <= w_synced;
      r_rise <= w_accept & w_synced;
    end
  end

  assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cpu_run_ctrl                                               |
// | Description : Board-side reset / clock-enable generator for Controller.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = C_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = C_HOLD_CYCLES,
  parameter int CNT_W           = C_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             BtnRst,
  input  logic             StepBtn,
  input  logic             RunMode,
  input  logic             CpuHalt,
  output logic             CpuReset,
  output logic             CpuEn,
  output logic             Halted,
  output logic [CNT_W-1:0] CycleCount
);

  localparam int c_hold_w = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t                 r_state;
  state_t                 w_next;
  logic [c_hold_w-1:0]    r_hold;
  logic [SYNC_STAGES-1:0] r_run_sync;
  logic [CNT_W-1:0]       r_count;
  logic                   w_btn_rise;
  logic                   w_step_rise;
  logic                   w_run;
  logic                   w_hold_done;

  debounce_sync #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_rst (
    .clk   (Clk),
    .rst   (Reset),
    .i_raw (BtnRst),
    .o_rise(w_btn_rise)
  );

  debounce_sync #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step (
    .clk   (Clk),
    .rst   (Reset),
    .i_raw (StepBtn),
    .o_rise(w_step_rise)
  );

  assign w_run       = r_run_sync[SYNC_STAGES-1];
  assign w_hold_done = (r_hold == c_hold_w'(HOLD_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= S_RST;
      r_hold     <= '0;
      r_run_sync <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_next;
      r_run_sync <= {r_run_sync[SYNC_STAGES-2:0], RunMode};
      // a reset press while already in S_RST restarts the hold window
      if (r_state == S_RST && !w_btn_rise)
        r_hold <= r_hold + 1'b1;
      else
        r_hold <= '0;
      if (w_next == S_RST)
        r_count <= '0;
      else if (CpuEn && (r_count != '1))
        r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_btn_rise) begin
      w_next = S_RST;
    end else begin
      unique case (r_state)
        S_RST:       if (w_hold_done) w_next = w_run ? S_RUN : S_STEP_WAIT;
        S_RUN:       if (CpuHalt) w_next = S_HALT;
                     else if (!w_run) w_next = S_STEP_WAIT;
        S_STEP_WAIT: if (w_run) w_next = S_RUN;
                     else if (w_step_rise) w_next = S_STEP;
        S_STEP:      w_next = CpuHalt ? S_HALT : S_STEP_WAIT;
        S_HALT:      w_next = S_HALT;
        default:     w_next = S_RST;
      endcase
    end
  end

  assign CpuReset   = (r_state == S_RST);
  assign CpuEn      = (r_state == S_RUN) || (r_state == S_STEP);
  assign Halted     = (r_state == S_HALT);
  assign CycleCount = r_count;

endmodule
`default_nettype wire
